// File: rtl/tof_cal_ctrl.sv
// rtl/tof_cal_ctrl.sv - capture/replay sequencer feeding tof_cal
// Buffers the start hit plus stop hits during a trigger window, then replays them one at a time.
module tof_cal_ctrl #(
  parameter int MAX_HITS = 6,
  parameter int CAL_TO   = 8,
  parameter int OUT_TO   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  input  logic [15:0] cfg_window,
  input  logic [2:0]  cfg_max_hits,
  input  logic        hit_valid,
  input  logic [15:0] hit_code,
  input  logic [25:0] hit_cnt,
  output logic [15:0] decode_in,
  output logic [25:0] counter_in,
  output logic [2:0]  cnt,
  output logic [2:0]  num_cnt,
  output logic        tri_en,
  output logic        cal_en,
  input  logic        cal_stop,
  input  logic        out_valid,
  output logic        busy,
  output logic        done,
  output logic        hit_ovf,
  output logic        seq_err
);

  typedef enum logic [2:0] {IDLE, ARM, LOAD, CAL, WAIT, DONE} state_e;

  localparam logic [2:0] MAX_HITS_W = 3'(MAX_HITS);
  localparam logic [4:0] CAL_TO_M1  = 5'(CAL_TO - 1);
  localparam logic [4:0] OUT_TO_M1  = 5'(OUT_TO - 1);

  state_e      state_q, state_d;
  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  max_hits_q, max_hits_d;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [4:0]  tmo_q, tmo_d;
  logic        ov_seen_q, ov_seen_d;
  logic [15:0] decode_q, decode_d;
  logic [25:0] counter_q, counter_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  num_cnt_q, num_cnt_d;
  logic        tri_en_q, cal_en_q, busy_q, done_q;
  logic        hit_ovf_q, hit_ovf_d;
  logic        seq_err_q, seq_err_d;

  logic [41:0] hit_mem_q [MAX_HITS];
  logic        mem_we;
  logic [2:0]  mem_wa;
  logic [2:0]  wr_base;
  logic [2:0]  lim;
  logic [2:0]  max_hits_cfg;
  logic        adv;

  always_comb begin
    max_hits_cfg = cfg_max_hits;
    if (cfg_max_hits == 3'd0) begin
      max_hits_cfg = 3'd1;
    end else if (cfg_max_hits > MAX_HITS_W) begin
      max_hits_cfg = MAX_HITS_W;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    max_hits_d = max_hits_q;
    win_cnt_d  = win_cnt_q;
    tmo_d      = tmo_q;
    ov_seen_d  = ov_seen_q;
    decode_d   = decode_q;
    counter_d  = counter_q;
    cnt_d      = cnt_q;
    num_cnt_d  = num_cnt_q;
    hit_ovf_d  = 1'b0;
    seq_err_d  = 1'b0;
    mem_we     = 1'b0;
    mem_wa     = wr_ptr_q;
    wr_base    = wr_ptr_q;
    lim        = max_hits_q;
    adv        = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d    = ARM;
          wr_ptr_d   = 3'd0;
          win_cnt_d  = cfg_window;
          max_hits_d = max_hits_cfg;
        end
      end
      ARM: begin
        // A re-arm restarts the buffer; a hit in the same cycle becomes entry 0.
        if (trig) begin
          wr_base    = 3'd0;
          lim        = max_hits_cfg;
          win_cnt_d  = cfg_window;
          max_hits_d = max_hits_cfg;
        end else begin
          win_cnt_d = win_cnt_q - 16'd1;
        end
        wr_ptr_d = wr_base;
        if (hit_valid) begin
          if (wr_base < lim) begin
            mem_we   = 1'b1;
            mem_wa   = wr_base;
            wr_ptr_d = wr_base + 3'd1;
          end else begin
            hit_ovf_d = 1'b1;
          end
        end
        if ((!trig && win_cnt_q == 16'd0) || (mem_we && wr_ptr_d == lim)) begin
          state_d = (wr_ptr_d != 3'd0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        state_d  = CAL;
        rd_ptr_d = 3'd0;
      end
      CAL: begin
        if (out_valid) begin
          ov_seen_d = 1'b1;
        end
        if (cal_stop) begin
          state_d = WAIT;
          tmo_d   = 5'd0;
        end else if (tmo_q == CAL_TO_M1) begin
          state_d   = WAIT;
          tmo_d     = 5'd0;
          seq_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 5'd1;
        end
      end
      WAIT: begin
        if (out_valid || ov_seen_q) begin
          adv = 1'b1;
        end else if (tmo_q == OUT_TO_M1) begin
          adv       = 1'b1;
          seq_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 5'd1;
        end
        if (adv) begin
          rd_ptr_d = rd_ptr_q + 3'd1;
          state_d  = (rd_ptr_q == wr_ptr_q - 3'd1) ? DONE : CAL;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == LOAD) begin
      num_cnt_d = wr_ptr_d - 3'd1;
    end
    // Data outputs are loaded once per entry so they are stable for the whole CAL/WAIT pair.
    if (state_d == CAL && state_q != CAL) begin
      {decode_d, counter_d} = hit_mem_q[rd_ptr_d];
      cnt_d     = rd_ptr_d + 3'd1;
      tmo_d     = 5'd0;
      ov_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      hit_mem_q[mem_wa] <= {hit_code, hit_cnt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= 3'd0;
      rd_ptr_q   <= 3'd0;
      max_hits_q <= 3'd1;
      win_cnt_q  <= 16'd0;
      tmo_q      <= 5'd0;
      ov_seen_q  <= 1'b0;
      decode_q   <= 16'd0;
      counter_q  <= 26'd0;
      cnt_q      <= 3'd0;
      num_cnt_q  <= 3'd0;
      tri_en_q   <= 1'b0;
      cal_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_ovf_q  <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      max_hits_q <= max_hits_d;
      win_cnt_q  <= win_cnt_d;
      tmo_q      <= tmo_d;
      ov_seen_q  <= ov_seen_d;
      decode_q   <= decode_d;
      counter_q  <= counter_d;
      cnt_q      <= cnt_d;
      num_cnt_q  <= num_cnt_d;
      tri_en_q   <= (state_d == LOAD);
      cal_en_q   <= (state_d == CAL);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
      hit_ovf_q  <= hit_ovf_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign decode_in  = decode_q;
  assign counter_in = counter_q;
  assign cnt        = cnt_q;
  assign num_cnt    = num_cnt_q;
  assign tri_en     = tri_en_q;
  assign cal_en     = cal_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign hit_ovf    = hit_ovf_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_tof_cal_ctrl.sv
// tb/tb_tof_cal_ctrl.sv - randomized bench for tof_cal_ctrl against a transaction-level model
module tb_tof_cal_ctrl;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic [15:0] cfg_window;
  logic [2:0]  cfg_max_hits;
  logic        hit_valid;
  logic [15:0] hit_code;
  logic [25:0] hit_cnt;
  logic [15:0] decode_in;
  logic [25:0] counter_in;
  logic [2:0]  cnt;
  logic [2:0]  num_cnt;
  logic        tri_en;
  logic        cal_en;
  logic        cal_stop;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        hit_ovf;
  logic        seq_err;

  tof_cal_ctrl dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .cfg_window(cfg_window), .cfg_max_hits(cfg_max_hits),
    .hit_valid(hit_valid), .hit_code(hit_code), .hit_cnt(hit_cnt), .decode_in(decode_in),
    .counter_in(counter_in), .cnt(cnt), .num_cnt(num_cnt), .tri_en(tri_en), .cal_en(cal_en),
    .cal_stop(cal_stop), .out_valid(out_valid), .busy(busy), .done(done), .hit_ovf(hit_ovf),
    .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Hit schedule indexed by ARM-relative cycle, plus per-entry responder behaviour.
  bit          hit_at [64];
  logic [15:0] hcode  [64];
  logic [25:0] hcnt   [64];
  int          cs_dly [6];
  int          ov_mode[6];
  int          ov_dly [6];
  logic [15:0] e_code [6];
  logic [25:0] e_cnt  [6];
  int          e_n, e_L, e_se;
  int          last_n = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int exp_cal(input int p);
    return (cs_dly[p] >= 8) ? 8 : cs_dly[p] + 1;
  endfunction

  function automatic int exp_wait(input int p);
    if (ov_mode[p] == 0) return 1;
    if (ov_mode[p] == 1) return ov_dly[p] + 1;
    return 16;
  endfunction

  task automatic clear_sched();
    for (int k = 0; k < 64; k++) begin
      hit_at[k] = 1'b0;
      hcode[k]  = 16'd0;
      hcnt[k]   = 26'd0;
    end
    for (int p = 0; p < 6; p++) begin
      cs_dly[p]  = 1;
      ov_mode[p] = 1;
      ov_dly[p]  = 0;
    end
  endtask

  task automatic add_hit(input int k, input logic [15:0] code, input logic [25:0] cv);
    hit_at[k] = 1'b1;
    hcode[k]  = code;
    hcnt[k]   = cv;
  endtask

  task automatic drive_idle();
    trig = 1'b0; hit_valid = 1'b0; hit_code = 16'd0; hit_cnt = 26'd0;
    cal_stop = 1'b0; out_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_cal_en"}, int'(cal_en), 0);
    chk({tag, "_tri_en"}, int'(tri_en), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_seq_err"}, int'(seq_err), 0);
    chk({tag, "_hit_ovf"}, int'(hit_ovf), 0);
    chk({tag, "_cnt"}, int'(cnt), 0);
    chk({tag, "_num_cnt"}, int'(num_cnt), 0);
    chk({tag, "_decode"}, int'(decode_in), 0);
    chk({tag, "_counter"}, int'(counter_in), 0);
  endtask

  task automatic run_meas(input int w, input int mh, input int rearm_at, input bit trig_late,
                          input bit abort_wait);
    int lim, wend, c, pass, pi, cal_len, wcyc;
    int tri_seen, tri_c, tri_num, done_seen, done_c, se_seen, ovf_seen;
    bit prev_cal, in_wait, fin, wrote;

    // Model: which hits land in the buffer and when the window closes.
    lim  = (mh == 0) ? 1 : ((mh > 6) ? 6 : mh);
    e_n  = 0;
    wend = w;
    e_L  = -1;
    for (int k = 0; k < 64; k++) begin
      wrote = 1'b0;
      if (k == rearm_at) begin
        e_n  = 0;
        wend = k + 1 + w;
      end
      if (hit_at[k] && e_n < lim) begin
        e_code[e_n] = hcode[k];
        e_cnt[e_n]  = hcnt[k];
        e_n++;
        wrote = 1'b1;
      end
      if ((wrote && e_n == lim) || k == wend) begin
        e_L = k + 1;
        break;
      end
    end
    e_se = 0;
    for (int p = 0; p < e_n; p++) begin
      e_se += ((cs_dly[p] >= 8) ? 1 : 0) + ((ov_mode[p] == 2) ? 1 : 0);
    end

    @(negedge clk);
    drive_idle();
    cfg_window   = 16'(w);
    cfg_max_hits = 3'(mh);
    trig         = 1'b1;
    hit_valid    = 1'b1;
    hit_code     = 16'hDEAD;
    hit_cnt      = 26'h155;
    @(negedge clk);

    c = 0; pass = -1; cal_len = 0; wcyc = 0; prev_cal = 0; in_wait = 0; fin = 0;
    tri_seen = 0; tri_c = -1; tri_num = -1; done_seen = 0; done_c = -1; se_seen = 0; ovf_seen = 0;
    while (!fin && c < 1000) begin
      if (c == 0) chk("busy_rise", int'(busy), 1);
      pi = (pass < 0) ? 0 : ((pass > 5) ? 5 : pass);
      if (tri_en) begin tri_seen++; tri_c = c; tri_num = int'(num_cnt); end
      if (done) begin done_seen++; done_c = c; end
      if (seq_err) se_seen++;
      if (hit_ovf) ovf_seen++;
      if (cal_en) begin
        if (!prev_cal) begin
          if (pass >= 0) chk("wait_len", wcyc + 1, exp_wait(pi));
          pass++;
          pi = (pass > 5) ? 5 : pass;
          cal_len = 0;
          if (pass < e_n) begin
            chk("cnt", int'(cnt), pass + 1);
            chk("decode_in", int'(decode_in), int'(e_code[pass]));
            chk("counter_in", int'(counter_in), int'(e_cnt[pass]));
          end
        end
        cal_len++;
        in_wait = 0;
      end else if (prev_cal) begin
        chk("cal_len", cal_len, exp_cal(pi));
        chk("hold_decode", int'(decode_in), int'(e_code[pi]));
        chk("hold_cnt", int'(cnt), pi + 1);
        in_wait = 1;
        wcyc = 0;
      end else if (in_wait) begin
        if (done) begin
          chk("wait_len", wcyc + 1, exp_wait(pi));
          in_wait = 0;
        end else begin
          wcyc++;
        end
      end
      prev_cal = cal_en;

      if (abort_wait && in_wait && pass == 0 && wcyc == 1) begin
        drive_idle();
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        last_n = 0;
        return;
      end

      drive_idle();
      if (c < 64 && hit_at[c]) begin
        hit_valid = 1'b1;
        hit_code  = hcode[c];
        hit_cnt   = hcnt[c];
      end
      cal_stop  = cal_en && (cal_len - 1 == cs_dly[pi]);
      out_valid = (cal_en && ov_mode[pi] == 0 && cal_len == 1) ||
                  (in_wait && ov_mode[pi] == 1 && wcyc == ov_dly[pi]);
      trig = (c == rearm_at) || (trig_late && ((cal_en && cal_len == 1 && pass == 0) || done));
      if (done) fin = 1;
      @(negedge clk);
      c++;
    end

    if (!fin) chk("done_timeout", 0, 1);
    drive_idle();
    chk("busy_fall", int'(busy), 0);
    chk("tri_count", tri_seen, (e_n > 0) ? 1 : 0);
    if (e_n > 0) begin
      chk("tri_at", tri_c, e_L);
      chk("num_cnt", tri_num, e_n - 1);
      chk("num_hold", int'(num_cnt), e_n - 1);
    end else begin
      chk("done_at", done_c, e_L);
      if (last_n > 0) chk("num_keep", int'(num_cnt), last_n - 1);
    end
    chk("passes", pass + 1, e_n);
    chk("done_count", done_seen, 1);
    chk("seq_err_count", se_seen, e_se);
    chk("hit_ovf_count", ovf_seen, 0);
    @(negedge clk);
    chk("idle_after", int'(busy), 0);
    if (e_n > 0) last_n = e_n;
  endtask

  initial begin
    int w, mh, ra;
    rst_n = 1'b0;
    cfg_window = 16'd0;
    cfg_max_hits = 3'd0;
    drive_idle();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_idle_busy", int'(busy), 0);

    clear_sched();
    add_hit(2, 16'h00FF, 26'd1002);
    add_hit(5, 16'h0FFF, 26'd1005);
    add_hit(9, 16'h003F, 26'd1009);
    run_meas(20, 3, -1, 1'b0, 1'b0);

    clear_sched();
    for (int i = 0; i < 8; i++) add_hit(2 + 2 * i, 16'(16'h0001 << i), 26'(500 + i));
    run_meas(40, 6, -1, 1'b0, 1'b0);

    clear_sched();
    run_meas(10, 2, -1, 1'b0, 1'b0);

    clear_sched();
    add_hit(1, 16'h7FFF, 26'd11);
    add_hit(2, 16'h0007, 26'd12);
    cs_dly[0] = 99; ov_mode[0] = 2;
    cs_dly[1] = 2;  ov_mode[1] = 0;
    run_meas(5, 2, -1, 1'b0, 1'b0);

    clear_sched();
    add_hit(1, 16'h0001, 26'd21);
    add_hit(3, 16'h0003, 26'd23);
    add_hit(6, 16'h000F, 26'd26);
    add_hit(8, 16'h00FF, 26'd28);
    add_hit(30, 16'hFFFF, 26'd30);
    run_meas(20, 4, 6, 1'b1, 1'b0);

    clear_sched();
    add_hit(0, 16'h1111, 26'd40);
    add_hit(1, 16'h2222, 26'd41);
    cs_dly[0] = 0; ov_mode[0] = 2;
    run_meas(3, 2, -1, 1'b0, 1'b1);
    chk_all_zero("post_rst");

    clear_sched();
    add_hit(3, 16'h0F0F, 26'd77);
    run_meas(5, 1, -1, 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      clear_sched();
      w  = int'($urandom_range(0, 40));
      mh = int'($urandom_range(0, 7));
      ra = -1;
      if ($urandom_range(0, 3) == 0) begin
        if (w > 25) w = 25;
        ra = int'($urandom_range(0, w));
      end
      for (int k = 0; k < 64; k++) begin
        if ($urandom_range(0, 3) == 0) add_hit(k, 16'($urandom), 26'($urandom));
      end
      for (int p = 0; p < 6; p++) begin
        cs_dly[p]  = int'($urandom_range(0, 9));
        ov_mode[p] = int'($urandom_range(0, 2));
        ov_dly[p]  = int'($urandom_range(0, 4));
      end
      run_meas(w, mh, ra, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tof_cal_ctrl.md
# tof_cal_ctrl

Sequencer for the TOF calculation pipeline. It arms on a laser trigger and captures the start hit plus up to five stop hits (16-bit thermometer fine code + 26-bit coarse counter) into a small buffer during a programmable window. It then replays each hit into `tof_cal` one at a time, driving `cal_en`/`cnt`/`num_cnt`/`tri_en`, and waits for each result before issuing the next. It sits between the TDC front-end capture logic and `tof_cal`.

## Interface
- `MAX_HITS`, 6: buffer depth; entry 0 is the start hit, entries 1..MAX_HITS-1 are stops.
- `CAL_TO`, 8: max cycles `cal_en` stays high waiting for `cal_stop`.
- `OUT_TO`, 16: max cycles waiting for `out_valid` after `cal_en` drops.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `trig` in 1: one-cycle laser-fire pulse; arms a measurement.
- `cfg_window` in 16: capture window length in cycles, sampled on accepted `trig`.
- `cfg_max_hits` in 3: hits to capture, including start; 0 is treated as 1, values above MAX_HITS as MAX_HITS; sampled on accepted `trig`.
- `hit_valid` in 1: front-end hit strobe.
- `hit_code` in 16: fine thermometer code for the hit.
- `hit_cnt` in 26: coarse counter snapshot for the hit.
- `decode_in` out 16: code to `tof_cal`.
- `counter_in` out 26: coarse count to `tof_cal`.
- `cnt` out 3: hit index to `tof_cal` (1 = start, 2..6 = stops).
- `num_cnt` out 3: captured hits minus 1.
- `tri_en` out 1: one-cycle pulse so `tof_cal` latches `num_cnt`.
- `cal_en` out 1: calculation enable.
- `cal_stop` in 1: `tof_cal` decode pass complete.
- `out_valid` in 1: `tof_cal` result strobe.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse when a measurement sequence finishes.
- `hit_ovf` out 1: one-cycle pulse when an ARM-state hit is dropped because the buffer is full.
- `seq_err` out 1: one-cycle pulse on a `cal_stop` or `out_valid` timeout.

## Operation
- States: IDLE, ARM, LOAD, CAL, WAIT, DONE.
- IDLE:
  - `trig` -> ARM.
  - Clear `wr_ptr`; load `win_cnt` = `cfg_window`; latch clamped `max_hits`.
  - `hit_valid` is ignored.
- ARM:
  - `hit_valid` with `wr_ptr` < `max_hits`: write {`hit_code`, `hit_cnt`} to entry `wr_ptr`, then `wr_ptr`++.
  - `hit_valid` with a full buffer: drop the hit and pulse `hit_ovf`.
  - `win_cnt` decrements each cycle.
  - Exit when `win_cnt` == 0, or when the write makes `wr_ptr` == `max_hits`.
  - A hit in the exit cycle is still captured.
  - Exit to LOAD if `wr_ptr` > 0 after the write; otherwise to DONE.
  - `trig` in ARM re-arms: clear `wr_ptr`, reload `win_cnt` and config. A same-cycle hit is captured as entry 0 of the new measurement.
- LOAD (1 cycle):
  - `tri_en` = 1, `num_cnt` = `wr_ptr`-1.
  - `rd_ptr` = 0; go to CAL.
- CAL:
  - Drive `decode_in`/`counter_in` from entry `rd_ptr`, `cnt` = `rd_ptr`+1, `cal_en` = 1.
  - On `cal_stop` sampled high, or after CAL_TO cycles (pulse `seq_err`): go to WAIT. `cal_en` is 0 from the next cycle.
- WAIT:
  - Data outputs hold; `cal_en` = 0.
  - On `out_valid`, or after OUT_TO cycles (pulse `seq_err`): `rd_ptr`++.
  - If `rd_ptr` == `wr_ptr`-1, go to DONE; else go to CAL.
  - An `out_valid` seen during CAL is also accepted; WAIT then lasts 1 cycle.
- DONE (1 cycle): `done` = 1, then IDLE.
- `trig` in LOAD, CAL, WAIT or DONE is ignored (no queueing).
- `num_cnt` holds its value from LOAD until the next LOAD.
- `decode_in`, `counter_in` and `cnt` hold their last values outside CAL/WAIT.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including `busy`, `done`, `hit_ovf`, `seq_err`, `tri_en` and `cal_en`.
  - Buffer contents need no reset.
- `trig` at edge N: `busy` = 1 from N+1.
- Window: ARM lasts `cfg_window`+1 cycles if the buffer does not fill; `cfg_window` = 0 gives a one-cycle ARM.
- LOAD is the cycle after ARM exit; the first `cal_en` is the cycle after LOAD.
- `cal_en` is registered. The data outputs change in the same cycle `cal_en` rises and stay stable until the next CAL entry.
- Per-entry minimum: 1 CAL cycle + 1 WAIT cycle.
- Reset mid-sequence: immediate return to IDLE; `cal_en` and `tri_en` drop asynchronously.
- `rd_ptr`/`wr_ptr` are 3 bits; `cnt` never exceeds MAX_HITS.

## Test plan
- `cfg_window`=20, `cfg_max_hits`=3, hits at +2/+5/+9 (codes 0x00FF/0x0FFF/0x003F):
  - `tri_en` fires with `num_cnt`=2.
  - Three CAL passes with `cnt`=1,2,3 and matching codes/counters.
  - `done` pulses once.
- `cfg_max_hits`=6 with 8 hits in the window:
  - ARM exits on the 6th hit; no `hit_ovf` for the later hits, since the state is no longer ARM.
  - `cnt` runs 1..6.
- Window 10 with no hits: ARM→DONE after 11 cycles; `cal_en` and `tri_en` never assert.
- `cal_stop` tied low:
  - `cal_en` high exactly 8 cycles, then `seq_err` pulses.
  - `out_valid` never arrives: a second `seq_err` after 16 cycles; the next entry proceeds.
- `trig` in ARM after 2 hits re-arms with `wr_ptr`=0. `trig` during CAL is ignored and the sequence completes unchanged.
- `rst_n` low during WAIT: all outputs 0 immediately; the next `trig` starts a clean measurement with `cnt`=1.
